// File: rtl/module_display_scan.sv
// rtl/module_display_scan.sv - multiplexed hex display scanner with frame-synchronous loads (optional LEADING_ZERO_BLANK_EN)
module module_display_scan #(
    parameter int CLK_FREQ  = 10_000_000,
    parameter int SCAN_FREQ = 1_000,
    parameter int N_DIGITS  = 8
) (
    input  logic                    clk_10Mhz_i,
    input  logic                    reset_i,
    input  logic [4*N_DIGITS-1:0]   data_i,
    input  logic                    load_i,
    input  logic [N_DIGITS-1:0]     en_mask_i,
    output logic [N_DIGITS-1:0]     anodo_o,
    output logic [6:0]              catodo_o,
    output logic                    load_ack_o,
    output logic                    frame_o
);

    localparam int DIV   = CLK_FREQ / SCAN_FREQ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = $clog2(N_DIGITS);

    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] ONE_HOT0 = N_DIGITS'(1);

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic                  tick;
    logic                  wrap;
    logic                  pend_vld;
    logic [4*N_DIGITS-1:0] pend_data;
    logic [4*N_DIGITS-1:0] disp_data;
    logic [3:0]            cur_nib;
    logic                  lz_ok;
    logic                  digit_on;

    function automatic logic [6:0] seg_decode(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // The last cycle of a digit slot; wrap marks the last slot of a whole frame.
    assign tick = (cnt == CNT_LAST);
    assign wrap = tick && (idx == IDX_LAST) && !reset_i;

    assign frame_o    = wrap;
    assign load_ack_o = wrap && (load_i || pend_vld);

    // Slot timer and digit index; reset restarts a full slot on digit 0.
    always_ff @(posedge clk_10Mhz_i) begin
        if (reset_i) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Loads wait in a pending buffer and only reach the display at a frame boundary, so a frame never mixes old and new data.
    always_ff @(posedge clk_10Mhz_i) begin
        if (reset_i) begin
            pend_vld  <= 1'b0;
            pend_data <= '0;
            disp_data <= '0;
        end else if (wrap) begin
            if (load_i) begin
                disp_data <= data_i;
            end else if (pend_vld) begin
                disp_data <= pend_data;
            end
            pend_vld <= 1'b0;
        end else if (load_i) begin
            pend_data <= data_i;
            pend_vld  <= 1'b1;
        end
    end

    assign cur_nib = disp_data[{idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] hi_nz;

    // Highest nonzero nibble; digit 0 stays visible even when everything is zero.
    always_comb begin
        hi_nz = '0;
        for (int k = 1; k < N_DIGITS; k++) begin
            if (disp_data[4*k +: 4] != 4'h0) begin
                hi_nz = IDX_W'(k);
            end
        end
        lz_ok = (idx <= hi_nz);
    end
`else
    assign lz_ok = 1'b1;
`endif

    assign digit_on = en_mask_i[idx] && lz_ok;

    // Registered drive of anode select and segments for the current digit.
    always_ff @(posedge clk_10Mhz_i) begin
        if (reset_i) begin
            anodo_o  <= '1;
            catodo_o <= 7'h7F;
        end else if (digit_on) begin
            anodo_o  <= ~(ONE_HOT0 << idx);
            catodo_o <= seg_decode(cur_nib);
        end else begin
            anodo_o  <= '1;
            catodo_o <= 7'h7F;
        end
    end

endmodule

// File: doc/module_display_scan.md
MODULE_DISPLAY_SCAN -- requirements
Module: module_display_scan

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 10_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter SCAN_FREQ, default 1_000, per-digit scan rate in Hz.
REQ-003 SHALL have parameter N_DIGITS, default 8, number of multiplexed digits (legal range 2..16).
REQ-004 SHALL have port clk_10Mhz_i, input, 1, the only clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have port data_i, input, 4*N_DIGITS, hex nibbles; nibble k drives digit k, and digit 0 is least significant.
REQ-007 SHALL have port load_i, input, 1, one-cycle request to capture data_i.
REQ-008 SHALL have port en_mask_i, input, N_DIGITS, per-digit enable where 1 means shown.
REQ-009 SHALL have port anodo_o, output, N_DIGITS, active-low one-hot digit select.
REQ-010 SHALL have port catodo_o, output, 7, active-low segments with bit6..0 = g,f,e,d,c,b,a.
REQ-011 SHALL have port load_ack_o, output, 1, one-cycle pulse when captured data becomes displayed.
REQ-012 SHALL have port frame_o, output, 1, one-cycle pulse on the last tick of each full scan frame.

Function
REQ-013 SHALL define DIV = CLK_FREQ/SCAN_FREQ (integer); the tick counter is $clog2(DIV) bits wide and counts 0..DIV-1.
REQ-014 SHALL raise an internal tick for one cycle when the counter equals DIV-1, then wrap the counter to 0.
REQ-015 SHALL advance the digit index by 1 on each tick, wrapping from N_DIGITS-1 to 0.
REQ-016 SHALL assert frame_o on the tick where the index wraps from N_DIGITS-1 to 0.
REQ-017 SHALL latch data_i into a pending register and set a pending flag when load_i=1.
REQ-018 SHALL overwrite the pending value on a repeated load_i while pending is set, so the last load wins.
REQ-019 SHALL copy pending into the display register on the frame_o cycle, clear pending, and pulse load_ack_o in that cycle.
REQ-020 SHALL load data_i directly into the display register and pulse load_ack_o when load_i coincides with the frame_o cycle.
REQ-021 SHALL leave the display register unchanged mid-frame, so no tearing occurs.
REQ-022 SHALL register anodo_o and catodo_o, each updating one cycle after the index or display register changes.
REQ-023 SHALL drive anodo_o as all-ones except bit idx=0 when digit idx is shown.
REQ-024 SHALL drive anodo_o all-ones and catodo_o 7'h7F when digit idx is blanked (en_mask_i[idx]=0).
REQ-025 SHALL decode hex 0..F to standard segments: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E (hex).

Reset
REQ-026 SHALL clear the counter, index, pending flag, pending register and display register while reset_i=1.
REQ-027 SHALL hold anodo_o at all-ones, catodo_o at 7'h7F, and load_ack_o and frame_o at 0 while reset_i=1.
REQ-028 SHALL drop any pending load when reset_i asserts mid-frame.
REQ-029 SHALL start a full DIV-cycle slot on digit 0 on the first cycle after reset deasserts.

Configuration
REQ-030 SHALL, when LEADING_ZERO_BLANK_EN is defined, blank every digit above the highest nonzero nibble of the display register; digit 0 is never blanked by this rule, and the rule ANDs with en_mask_i.
REQ-031 SHALL, when LEADING_ZERO_BLANK_EN is undefined, show all digits enabled by en_mask_i, zeros included.

Verification
All scenarios use CLK_FREQ=10_000_000, SCAN_FREQ=1_000_000 (DIV=10), N_DIGITS=4, and en_mask_i=4'hF unless stated.
REQ-032 SHALL check: reset, then free-run -> anodo_o cycles 1110,1101,1011,0111 with 10 cycles each; frame_o pulses every 40 cycles.
REQ-033 SHALL check: load_i with data_i=16'h1234 at cycle 5 of the frame -> digits unchanged until wrap; load_ack_o pulses once at frame_o; then digit 0 shows catodo_o=7'h19 and digit 3 shows 7'h79.
REQ-034 SHALL check: loads of 16'hAAAA then 16'h5555 in the same frame -> a single load_ack_o, and all digits show 7'h12.
REQ-035 SHALL check: load_i in the exact frame_o cycle -> immediate capture with load_ack_o in that cycle.
REQ-036 SHALL check: en_mask_i=4'b0101 -> digit 1 and digit 3 slots give anodo_o=1111 and catodo_o=7'h7F; reset at a digit 2 slot gives anodo_o=1111 the next cycle, then digit 0 for 10 cycles.
REQ-037 SHALL check, with LEADING_ZERO_BLANK_EN defined: data 16'h0007 -> digits 1..3 blanked and digit 0 shows 7'h78; data 16'h0000 -> only digit 0 shows, at 7'h40.
